// File: rtl/muldiv_sequencer.sv
// Sequences the shared mult/div units: start pulse, wait for stop/divzero, then HI/LO write or exception.
// Request to start pulse: 1 cycle; write lands k+2 cycles after the request; busy stalls the control FSM meanwhile.
module muldiv_sequencer #(
   parameter int MULT_TIMEOUT = 40,
   parameter int DIV_TIMEOUT  = 40,
   parameter int CNT_W        = 6
) (
   input  logic clock,
   input  logic reset,
   input  logic reqmult,
   input  logic reqdiv,
   input  logic stopmult,
   input  logic divstop,
   input  logic divzero,
   output logic startmult,
   output logic startdiv,
   output logic divmultmux,
   output logic reghighw,
   output logic regloww,
   output logic busy,
   output logic mddone,
   output logic excdivzero,
   output logic exctimeout
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      MSTART = 3'd1,
      MWAIT  = 3'd2,
      DSTART = 3'd3,
      DWAIT  = 3'd4,
      WB     = 3'd5,
      EXC    = 3'd6
   } state_t;

   localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

   state_t           state;
   logic [CNT_W-1:0] cnt;

   // Outputs are registered alongside the state they belong to, so pulses are set on entry.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         startmult  <= 1'b0;
         startdiv   <= 1'b0;
         divmultmux <= 1'b0;
         reghighw   <= 1'b0;
         regloww    <= 1'b0;
         busy       <= 1'b0;
         mddone     <= 1'b0;
         excdivzero <= 1'b0;
         exctimeout <= 1'b0;
      end else begin
         startmult  <= 1'b0;
         startdiv   <= 1'b0;
         reghighw   <= 1'b0;
         regloww    <= 1'b0;
         mddone     <= 1'b0;
         excdivzero <= 1'b0;
         exctimeout <= 1'b0;
         case (state)
            IDLE: begin
               if (reqmult) begin
                  state      <= MSTART;
                  startmult  <= 1'b1;
                  divmultmux <= 1'b1;
                  busy       <= 1'b1;
               end else if (reqdiv) begin
                  state      <= DSTART;
                  startdiv   <= 1'b1;
                  divmultmux <= 1'b0;
                  busy       <= 1'b1;
               end
            end
            MSTART: begin
               state <= MWAIT;
               cnt   <= '0;
            end
            MWAIT: begin
               if (stopmult) begin
                  state    <= WB;
                  reghighw <= 1'b1;
                  regloww  <= 1'b1;
                  mddone   <= 1'b1;
               end else if (cnt == MULT_LAST) begin
                  state      <= EXC;
                  exctimeout <= 1'b1;
               end else if (cnt != CNT_MAX) begin
                  cnt <= cnt + 1'b1;
               end
            end
            DSTART: begin
               // A zero divisor can be flagged as soon as the divider sees its start pulse.
               if (divzero) begin
                  state      <= EXC;
                  excdivzero <= 1'b1;
               end else begin
                  state <= DWAIT;
                  cnt   <= '0;
               end
            end
            DWAIT: begin
               if (divzero) begin
                  state      <= EXC;
                  excdivzero <= 1'b1;
               end else if (divstop) begin
                  state    <= WB;
                  reghighw <= 1'b1;
                  regloww  <= 1'b1;
                  mddone   <= 1'b1;
               end else if (cnt == DIV_LAST) begin
                  state      <= EXC;
                  exctimeout <= 1'b1;
               end else if (cnt != CNT_MAX) begin
                  cnt <= cnt + 1'b1;
               end
            end
            WB, EXC: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench: per-cycle checks of start/busy/mux, scoreboard of expected write/exception events.
module tb_muldiv_sequencer;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic reqmult = 1'b0, reqdiv = 1'b0, stopmult = 1'b0, divstop = 1'b0, divzero = 1'b0;
   logic startmult, startdiv, divmultmux, reghighw, regloww, busy, mddone, excdivzero, exctimeout;

   localparam logic [4:0] EV_WB = 5'b11100;
   localparam logic [4:0] EV_DZ = 5'b00010;
   localparam logic [4:0] EV_TO = 5'b00001;
   localparam int NONE = -1;

   typedef struct {
      int         cyc;
      logic [4:0] kind;
   } ev_t;

   ev_t sb[$];
   int  n_checks = 0;
   int  n_pass   = 0;
   logic last_mux = 1'b0;

   muldiv_sequencer #(.MULT_TIMEOUT(40), .DIV_TIMEOUT(40), .CNT_W(6)) dut (
      .clock(clock), .reset(reset), .reqmult(reqmult), .reqdiv(reqdiv),
      .stopmult(stopmult), .divstop(divstop), .divzero(divzero),
      .startmult(startmult), .startdiv(startdiv), .divmultmux(divmultmux),
      .reghighw(reghighw), .regloww(regloww), .busy(busy), .mddone(mddone),
      .excdivzero(excdivzero), .exctimeout(exctimeout)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [4:0] ev_vec();
      return {reghighw, regloww, mddone, excdivzero, exctimeout};
   endfunction

   // Cycle 0 carries the request; stop/zero cycles are relative to it, NONE means never.
   task automatic run_op(input string name, input bit mult, input bit both,
                         input int stop_cyc, input int zero_cyc, input int busy_req_cyc);
      int   e;
      int   z;
      int   s;
      ev_t  ev;
      ev_t  got_ev;
      logic [4:0] obs;
      if (mult) begin
         if (stop_cyc >= 2 && stop_cyc <= 41) begin e = stop_cyc + 1; ev.kind = EV_WB; end
         else begin e = 42; ev.kind = EV_TO; end
      end else begin
         z = (zero_cyc >= 1 && zero_cyc <= 41) ? zero_cyc : 1000;
         s = (stop_cyc >= 2 && stop_cyc <= 41) ? stop_cyc : 1000;
         if (z <= s && z < 1000) begin e = z + 1; ev.kind = EV_DZ; end
         else if (s < 1000) begin e = s + 1; ev.kind = EV_WB; end
         else begin e = 42; ev.kind = EV_TO; end
      end
      ev.cyc = e;
      sb.push_back(ev);
      for (int t = 0; t <= e + 1; t++) begin
         check($sformatf("%s startmult t%0d", name, t), 32'(startmult), 32'(mult && t == 1));
         check($sformatf("%s startdiv t%0d", name, t), 32'(startdiv), 32'(!mult && t == 1));
         check($sformatf("%s busy t%0d", name, t), 32'(busy), 32'(t >= 1 && t <= e));
         check($sformatf("%s divmultmux t%0d", name, t), 32'(divmultmux),
               32'((t >= 1) ? mult : last_mux));
         obs = ev_vec();
         if (obs != 5'b0) begin
            if (sb.size() == 0) begin
               check($sformatf("%s unexpected event t%0d", name, t), 32'(obs), 32'd0);
            end else begin
               got_ev = sb.pop_front();
               check($sformatf("%s event kind", name), 32'(obs), 32'(got_ev.kind));
               check($sformatf("%s event cycle", name), 32'(t), 32'(got_ev.cyc));
            end
         end
         reqmult  = (t == 0 && mult) || (t == busy_req_cyc);
         reqdiv   = (t == 0 && (!mult || both)) || (t == busy_req_cyc);
         stopmult = mult && (t == stop_cyc);
         divstop  = !mult && (t == stop_cyc);
         divzero  = (t == zero_cyc);
         tick();
      end
      reqmult = 1'b0; reqdiv = 1'b0; stopmult = 1'b0; divstop = 1'b0; divzero = 1'b0;
      check($sformatf("%s scoreboard drained", name), 32'(sb.size()), 32'd0);
      sb.delete();
      last_mux = mult;
   endtask

   function automatic logic [8:0] all_out();
      return {startmult, startdiv, divmultmux, reghighw, regloww, busy, mddone, excdivzero, exctimeout};
   endfunction

   initial begin
      #1;
      check("outputs in reset", 32'(all_out()), 32'd0);
      tick();
      reset = 1'b0;
      tick();
      check("idle after reset", 32'(all_out()), 32'd0);

      run_op("mult",       1'b1, 1'b0, 34,   NONE, NONE);
      run_op("div",        1'b0, 1'b0, 20,   NONE, NONE);
      run_op("divzero",    1'b0, 1'b0, 5,    5,    NONE);
      run_op("mtimeout",   1'b1, 1'b0, NONE, NONE, NONE);
      run_op("arb",        1'b1, 1'b1, 15,   NONE, 10);
      run_op("dzstart",    1'b0, 1'b0, NONE, 1,    NONE);
      run_op("dtimeout",   1'b0, 1'b0, NONE, NONE, NONE);
      run_op("mult_dzign", 1'b1, 1'b0, 12,   5,    NONE);
      run_op("div_short",  1'b0, 1'b0, 2,    NONE, NONE);

      // Asynchronous reset while the multiplier is outstanding.
      reqmult = 1'b1;
      tick();
      reqmult = 1'b0;
      check("rst startmult", 32'(startmult), 32'd1);
      repeat (4) tick();
      check("rst busy before", 32'(busy), 32'd1);
      #3;
      reset = 1'b1;
      #1;
      check("async reset outputs", 32'(all_out()), 32'd0);
      tick();
      tick();
      reset = 1'b0;
      stopmult = 1'b1;
      tick();
      stopmult = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("stale stopmult idle c%0d", i), 32'(all_out()), 32'd0);
         tick();
      end
      last_mux = 1'b0;
      run_op("div_after_rst", 1'b0, 1'b0, 7, NONE, NONE);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
